// File: rtl/prim_sync_reqack_arb_pkg.sv
// Shared types and helpers for the round-robin req/ack channel arbiter.
package prim_sync_reqack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } arb_state_e;

  localparam int DefaultN             = 4;
  localparam int DefaultWidth         = 8;
  localparam int DefaultTimeoutCycles = 1023;

  // Widest requester vector the pick helper handles.
  localparam int MaxN    = 16;
  localparam int MaxIdxW = 4;

  // Index of the first set bit of req[n-1:0], searching upward from ptr and
  // wrapping at n. Returns 0 when nothing is set; callers qualify with |req.
  function automatic logic [MaxIdxW-1:0] rr_first_set(
    input logic [MaxN-1:0]    req,
    input logic [MaxIdxW-1:0] ptr,
    input int                 n
  );
    logic               found;
    logic [MaxIdxW-1:0] idx;
    logic [MaxIdxW:0]   pos;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < MaxN; i++) begin
      pos = 5'(ptr) + 5'(i);
      if (pos >= 5'(n)) begin
        pos = pos - 5'(n);
      end
      if (i < n && !found && req[pos[MaxIdxW-1:0]]) begin
        found = 1'b1;
        idx   = pos[MaxIdxW-1:0];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/prim_sync_reqack_arb_rr_pick.sv
// Combinational rotating-priority pick: first requester at or above the
// pointer, wrapping around. Reusable by any round-robin arbiter up to 16 ways.
module prim_rr_pick
  import prim_sync_reqack_arb_pkg::*;
#(
  parameter  int N    = DefaultN,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            valid,
  output logic [IdxW-1:0] idx
);

  assign valid = |req;
  assign idx   = IdxW'(rr_first_set(MaxN'(req), MaxIdxW'(ptr), N));

endmodule

// File: rtl/prim_sync_reqack_arb.sv
// Round-robin arbiter sharing one source-side req/ack data channel among N
// requesters. A winner is latched in IDLE, held on the channel in GRANT until
// the channel acks, and a one-cycle GAP always follows so the channel request
// returns to zero between transactions. The downstream channel must be reset
// together with this block, since a reset here drops out_req_o mid-handshake.
module prim_sync_reqack_arb
  import prim_sync_reqack_arb_pkg::*;
#(
  parameter  int N             = DefaultN,
  parameter  int Width         = DefaultWidth,
  parameter  int TimeoutCycles = DefaultTimeoutCycles,
  localparam int IdxW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N-1:0]       req_i,
  input  logic [N*Width-1:0] data_i,
  output logic [N-1:0]       ack_o,
  output logic               out_req_o,
  input  logic               out_ack_i,
  output logic [Width-1:0]   out_data_o,
  output logic [IdxW-1:0]    gnt_idx_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int WdogW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [WdogW-1:0] WdogMax = WdogW'(TimeoutCycles);

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  ptr_q, win_q, next_ptr;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_valid;
  logic [Width-1:0] data_q, pick_data;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             err_q;
  logic             in_grant, ack_hit, win_req;
  logic             proto_err, spurious_ack, wdog_err;

  prim_rr_pick #(
    .N(N)
  ) u_pick (
    .req  (req_i),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign in_grant = (state_q == GRANT);
  assign ack_hit  = in_grant && out_ack_i;
  assign next_ptr = (win_q == IdxW'(N - 1)) ? '0 : win_q + 1'b1;

  // Select the data slice of the requester the pick logic is offering.
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < N; k++) begin
      if (pick_idx == IdxW'(k)) begin
        pick_data = data_i[k*Width +: Width];
      end
    end
  end

  // Route the channel ack to the latched winner and look at its request level.
  always_comb begin
    ack_o   = '0;
    win_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (win_q == IdxW'(k)) begin
        ack_o[k] = ack_hit;
        win_req  = req_i[k];
      end
    end
  end

  // Next-state logic: IDLE picks, GRANT waits for the ack, GAP forces a low cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = GRANT;
      GRANT:   if (out_ack_i)  state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Watchdog counts GRANT cycles without an ack, saturating at the limit.
  always_comb begin
    wdog_d = '0;
    if (TimeoutCycles != 0 && in_grant && !out_ack_i) begin
      wdog_d = (wdog_q == WdogMax) ? wdog_q : wdog_q + 1'b1;
    end
  end

  assign wdog_err     = (TimeoutCycles != 0) && in_grant && !out_ack_i && (wdog_d == WdogMax);
  assign proto_err    = in_grant && !out_ack_i && !win_req;
  assign spurious_ack = !in_grant && out_ack_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Winner/data capture, priority rotation, watchdog and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      win_q  <= '0;
      data_q <= '0;
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (state_q == IDLE && pick_valid) begin
        win_q  <= pick_idx;
        data_q <= pick_data;
      end
      if (ack_hit) begin
        ptr_q <= next_ptr;
      end
      if (proto_err || spurious_ack || wdog_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out_req_o  = in_grant;
  assign out_data_o = data_q;
  assign gnt_idx_o  = win_q;
  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;

endmodule
